jtsbaskt_snd_arb: RTL and testbench

- Shares one SDRAM read slot between the sound Z80 program ROM fetch and the VLM5030 speech-data (PCM) fetch inside the sound subsystem.
- Sequences SDRAM requests with a small FSM.
- Keeps a one-entry tag/data buffer per requester, so repeated reads of the same address are served without a new SDRAM access.
- Hands each requester a data/ok pair that matches the rom/pcm interface the sound CPU wrapper and VLM glue already expect.

---
 rtl/jtsbaskt_snd_arb.sv | 136 +++++++++++++
 tb/tb_jtsbaskt_snd_arb.sv | 355 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/jtsbaskt_snd_arb.sv
// Purpose: shares one SDRAM read slot between the sound Z80 ROM fetch and the VLM5030 PCM fetch; one-entry tag/data buffer per requester.
// Latency: hit 0 cycles (combinational ok); miss from idle slot: cs@0 -> mem_cs@1 -> mem_ok@n -> ok@n+1; one GAP cycle between slot requests.
// Backpressure: requesters hold cs until ok; slot request (mem_cs/mem_addr) held stable until mem_ok. Optional stats: JTSBASKT_ARB_STATS_EN.
module jtsbaskt_snd_arb #(
  parameter int                CPU_AW     = 13,
  parameter int                PCM_AW     = 16,
  parameter int                MEM_AW     = 17,
  parameter logic [MEM_AW-1:0] PCM_OFFSET = MEM_AW'('h02000)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cpu_cs,
  input  logic [CPU_AW-1:0] cpu_addr,
  output logic [7:0]        cpu_data,
  output logic              cpu_ok,
  input  logic              pcm_cs,
  input  logic [PCM_AW-1:0] pcm_addr,
  output logic [7:0]        pcm_data,
  output logic              pcm_ok,
  output logic [MEM_AW-1:0] mem_addr,
  output logic              mem_cs,
  input  logic [7:0]        mem_data,
  input  logic              mem_ok
`ifdef JTSBASKT_ARB_STATS_EN
  ,
  output logic [15:0]       stat_cpu_wait,
  output logic [15:0]       stat_pcm_wait
`endif
);

  typedef enum logic [1:0] {IDLE, RD_CPU, RD_PCM, GAP} state_t;

  state_t            state, state_nxt;
  logic              cpu_valid, pcm_valid;
  logic [CPU_AW-1:0] cpu_tag, cpu_ptag;
  logic [PCM_AW-1:0] pcm_tag, pcm_ptag;
  logic              last_pcm;
  logic              cpu_hit, pcm_hit, cpu_miss, pcm_miss;
  logic [MEM_AW-1:0] pcm_slot_addr;

  assign cpu_hit  = cpu_cs & cpu_valid & (cpu_tag == cpu_addr);
  assign pcm_hit  = pcm_cs & pcm_valid & (pcm_tag == pcm_addr);
  assign cpu_miss = cpu_cs & ~cpu_hit;
  assign pcm_miss = pcm_cs & ~pcm_hit;
  assign cpu_ok   = cpu_hit;
  assign pcm_ok   = pcm_hit;

  // PCM data lives after the CPU ROM in the same slot; wraps modulo the slot size
  assign pcm_slot_addr = PCM_OFFSET + MEM_AW'(pcm_addr);

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state: on a tie the side not served last wins, so neither can starve
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (pcm_miss && (!cpu_miss || !last_pcm)) state_nxt = RD_PCM;
        else if (cpu_miss)                        state_nxt = RD_CPU;
      end
      RD_CPU:  if (mem_ok) state_nxt = GAP;
      RD_PCM:  if (mem_ok) state_nxt = GAP;
      default: state_nxt = IDLE;
    endcase
  end

  // Slot request launch, buffer fill and fairness bookkeeping
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mem_cs    <= 1'b0;
      mem_addr  <= '0;
      cpu_valid <= 1'b0;
      pcm_valid <= 1'b0;
      cpu_tag   <= '0;
      pcm_tag   <= '0;
      cpu_ptag  <= '0;
      pcm_ptag  <= '0;
      cpu_data  <= '0;
      pcm_data  <= '0;
      last_pcm  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (state_nxt == RD_PCM) begin
            mem_cs   <= 1'b1;
            mem_addr <= pcm_slot_addr;
            pcm_ptag <= pcm_addr;
          end else if (state_nxt == RD_CPU) begin
            mem_cs   <= 1'b1;
            mem_addr <= MEM_AW'(cpu_addr);
            cpu_ptag <= cpu_addr;
          end
        end
        // The fill always uses the address latched at launch, even if the
        // requester moved on or dropped cs meanwhile
        RD_CPU: begin
          if (mem_ok) begin
            cpu_data  <= mem_data;
            cpu_tag   <= cpu_ptag;
            cpu_valid <= 1'b1;
            mem_cs    <= 1'b0;
            last_pcm  <= 1'b0;
          end
        end
        RD_PCM: begin
          if (mem_ok) begin
            pcm_data  <= mem_data;
            pcm_tag   <= pcm_ptag;
            pcm_valid <= 1'b1;
            mem_cs    <= 1'b0;
            last_pcm  <= 1'b1;
          end
        end
        default: mem_cs <= 1'b0;
      endcase
    end
  end

`ifdef JTSBASKT_ARB_STATS_EN
  // Saturating counts of cycles each requester spends waiting on a miss
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stat_cpu_wait <= '0;
      stat_pcm_wait <= '0;
    end else begin
      if (cpu_miss && stat_cpu_wait != 16'hFFFF) stat_cpu_wait <= stat_cpu_wait + 16'd1;
      if (pcm_miss && stat_pcm_wait != 16'hFFFF) stat_pcm_wait <= stat_pcm_wait + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_jtsbaskt_snd_arb.sv
// Purpose: self-checking bench for jtsbaskt_snd_arb: directed scenarios plus randomized two-requester traffic against a cache/arbiter model.
// Latency: memory model answers a configurable number of cycles after mem_cs rises.
// Backpressure: each requester holds cs until its ok is observed.
`timescale 1ns/1ps
module tb_jtsbaskt_snd_arb;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cpu_cs = 1'b0;
  logic [12:0] cpu_addr = '0;
  logic [7:0]  cpu_data;
  logic        cpu_ok;
  logic        pcm_cs = 1'b0;
  logic [15:0] pcm_addr = '0;
  logic [7:0]  pcm_data;
  logic        pcm_ok;
  logic [16:0] mem_addr;
  logic        mem_cs;
  logic [7:0]  mem_data = '0;
  logic        mem_ok = 1'b0;
`ifdef JTSBASKT_ARB_STATS_EN
  logic [15:0] stat_cpu_wait, stat_pcm_wait;
`endif

  jtsbaskt_snd_arb dut (
    .clk(clk), .rst_n(rst_n),
    .cpu_cs(cpu_cs), .cpu_addr(cpu_addr), .cpu_data(cpu_data), .cpu_ok(cpu_ok),
    .pcm_cs(pcm_cs), .pcm_addr(pcm_addr), .pcm_data(pcm_data), .pcm_ok(pcm_ok),
    .mem_addr(mem_addr), .mem_cs(mem_cs), .mem_data(mem_data), .mem_ok(mem_ok)
`ifdef JTSBASKT_ARB_STATS_EN
    , .stat_cpu_wait(stat_cpu_wait), .stat_pcm_wait(stat_pcm_wait)
`endif
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  always @(posedge clk) cyc = cyc + 1;

  // Reference content of the SDRAM slot
  function automatic logic [7:0] fdata(input logic [16:0] a);
    return a[7:0] ^ a[15:8] ^ {7'd0, a[16]} ^ 8'h3C;
  endfunction
  function automatic logic [16:0] pslot(input logic [15:0] a);
    return 17'h02000 + {1'b0, a};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // ---------------- memory model ----------------
  int   lat = 3;
  bit   rand_lat = 0;
  bit   ovr = 0;
  logic [7:0] ovr_data = '0;
  int   mcnt = 0;
  always @(posedge clk) begin
    #1;
    if (mem_cs && !mem_ok) begin
      if (mcnt == 0 && rand_lat) lat = $urandom_range(1, 4);
      mcnt++;
      if (mcnt == lat + 1) begin
        mem_ok   = 1'b1;
        mem_data = ovr ? ovr_data : fdata(mem_addr);
      end
    end else begin
      mem_ok = 1'b0;
      mcnt   = 0;
    end
  end

  // ---------------- scoreboard state ----------------
  bit          mon_en = 0;
  bit          prev_cs = 0;
  logic [16:0] held_addr = '0;
  logic [7:0]  cpu_exp[$];
  logic [7:0]  pcm_exp[$];
  bit          cpu_seen = 0, pcm_seen = 0;
  bit          cpu_pend = 0, pcm_pend = 0;
  logic [12:0] cpu_pend_addr = '0;
  logic [15:0] pcm_pend_addr = '0;
  int          cpu_pend_cyc = 0, pcm_pend_cyc = 0;
  bit          m_cpu_v = 0, m_pcm_v = 0;
  logic [12:0] m_cpu_tag = '0;
  logic [15:0] m_pcm_tag = '0;
  bit          m_last = 0;   // 1: PCM was served last

  // Monitor: pops expectations whenever the DUT presents a slot request or an ok
  always @(negedge clk) begin
    bit ce, pe, side, found;
    if (mon_en && rst_n) begin
      if (mem_cs && !prev_cs) begin
        ce = cpu_pend && (cpu_pend_cyc < cyc);
        pe = pcm_pend && (pcm_pend_cyc < cyc);
        found = 1'b1;
        side  = 1'b0;
        if (cpu_pend && mem_addr == {4'd0, cpu_pend_addr}) side = 1'b0;
        else if (pcm_pend && mem_addr == pslot(pcm_pend_addr)) side = 1'b1;
        else found = 1'b0;
        n_cmp++;
        if (!found) begin
          n_bad++;
          $display("FAIL slot_req_expected: got mem_addr %h, expected a pending miss (cpu %0d:%h pcm %0d:%h)",
                   mem_addr, cpu_pend, cpu_pend_addr, pcm_pend, pcm_pend_addr);
        end else begin
          if (ce && pe) chk("tie_alternates", {31'd0, side}, {31'd0, !m_last});
          m_last = side;
          if (side) pcm_pend = 0; else cpu_pend = 0;
        end
      end else if (mem_cs && prev_cs) begin
        chk("slot_addr_stable", {15'd0, mem_addr}, {15'd0, held_addr});
      end
      if (cpu_ok && cpu_cs && !cpu_seen) begin
        chk("cpu_ok_after_slot", {31'd0, cpu_pend}, 32'd0);
        if (cpu_exp.size() == 0) chk("cpu_ok_unexpected", 32'd1, 32'd0);
        else chk("cpu_data", {24'd0, cpu_data}, {24'd0, cpu_exp.pop_front()});
        cpu_seen = 1;
      end
      if (pcm_ok && pcm_cs && !pcm_seen) begin
        chk("pcm_ok_after_slot", {31'd0, pcm_pend}, 32'd0);
        if (pcm_exp.size() == 0) chk("pcm_ok_unexpected", 32'd1, 32'd0);
        else chk("pcm_data", {24'd0, pcm_data}, {24'd0, pcm_exp.pop_front()});
        pcm_seen = 1;
      end
    end
    if (mem_cs && !prev_cs) held_addr = mem_addr;
    prev_cs = mem_cs;
  end

  // ---------------- helpers ----------------
  task automatic step();
    @(posedge clk); #1;
  endtask

  // which: 0 mem_cs high, 1 cpu_ok, 2 pcm_ok, 3 mem_cs low; returns at a negedge
  task automatic wait_cond(input int which, input int max, input string name);
    bit hit = 0;
    for (int i = 0; i < max && !hit; i++) begin
      @(negedge clk);
      case (which)
        0: hit = mem_cs;
        1: hit = cpu_ok;
        2: hit = pcm_ok;
        default: hit = !mem_cs;
      endcase
    end
    if (!hit) begin
      n_cmp++; n_bad++;
      $display("FAIL %s: condition %0d not seen within %0d cycles", name, which, max);
    end
  endtask

  task automatic do_reset();
    step(); rst_n = 1'b0;
    step(); rst_n = 1'b1;
  endtask

  task automatic drive_cpu(input int n);
    for (int i = 0; i < n; i++) begin
      logic [12:0] a;
      case ($urandom_range(0, 3))
        0: a = 13'h0000;
        1: a = 13'h0010;
        2: a = 13'h1FFF;
        default: a = 13'h0ABC;
      endcase
      repeat ($urandom_range(0, 3)) step();
      cpu_addr = a; cpu_cs = 1'b1; cpu_seen = 0;
      cpu_exp.push_back(fdata({4'd0, a}));
      if (!(m_cpu_v && m_cpu_tag == a)) begin
        cpu_pend = 1; cpu_pend_addr = a; cpu_pend_cyc = cyc;
      end
      for (int t = 0; t < 100 && !cpu_seen; t++) step();
      if (!cpu_seen) chk("cpu_req_timeout", 32'd1, 32'd0);
      m_cpu_v = 1; m_cpu_tag = a;
      cpu_cs = 1'b0;
    end
  endtask

  task automatic drive_pcm(input int n);
    for (int i = 0; i < n; i++) begin
      logic [15:0] a;
      case ($urandom_range(0, 3))
        0: a = 16'h0000;
        1: a = 16'h0020;
        2: a = 16'hFFFF;
        default: a = 16'h8000;
      endcase
      repeat ($urandom_range(0, 3)) step();
      pcm_addr = a; pcm_cs = 1'b1; pcm_seen = 0;
      pcm_exp.push_back(fdata(pslot(a)));
      if (!(m_pcm_v && m_pcm_tag == a)) begin
        pcm_pend = 1; pcm_pend_addr = a; pcm_pend_cyc = cyc;
      end
      for (int t = 0; t < 100 && !pcm_seen; t++) step();
      if (!pcm_seen) chk("pcm_req_timeout", 32'd1, 32'd0);
      m_pcm_v = 1; m_pcm_tag = a;
      pcm_cs = 1'b0;
    end
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // ---------------- directed + random stimulus ----------------
  initial begin
    int t0;
    bit stable;
    logic [16:0] grants[4];
    int ng;
    bit bump_c, bump_p, pcs;

    repeat (3) @(posedge clk);
    #1;
    // Reset state
    @(negedge clk);
    chk("rst_mem_cs", {31'd0, mem_cs}, 32'd0);
    chk("rst_mem_addr", {15'd0, mem_addr}, 32'd0);
    chk("rst_oks", {30'd0, cpu_ok, pcm_ok}, 32'd0);
    chk("rst_data", {16'd0, cpu_data, pcm_data}, 32'd0);
`ifdef JTSBASKT_ARB_STATS_EN
    chk("rst_stats", {stat_cpu_wait, stat_pcm_wait}, 32'd0);
`endif
    step(); rst_n = 1'b1;

    // CPU miss then hit, 3-cycle memory latency, fixed data A5
    ovr = 1; ovr_data = 8'hA5; lat = 3;
    cpu_addr = 13'h0123; cpu_cs = 1'b1; t0 = cyc;
    wait_cond(0, 20, "t1_mem_cs");
    chk("t1_mem_cs_cycle", cyc - t0, 32'd1);
    chk("t1_mem_addr", {15'd0, mem_addr}, 32'h00123);
    wait_cond(1, 20, "t1_cpu_ok");
    chk("t1_ok_latency", cyc - t0, 32'd5);
    chk("t1_cpu_data", {24'd0, cpu_data}, 32'hA5);
`ifdef JTSBASKT_ARB_STATS_EN
    chk("stat_cpu_wait", {16'd0, stat_cpu_wait}, 32'd5);
    chk("stat_pcm_wait", {16'd0, stat_pcm_wait}, 32'd0);
`endif
    ovr = 0;
    step(); cpu_cs = 1'b0;
    step(); cpu_cs = 1'b1;
    @(negedge clk);
    chk("t1_reread_ok", {31'd0, cpu_ok}, 32'd1);
    chk("t1_reread_no_slot", {31'd0, mem_cs}, 32'd0);

    // PCM offset at the top of the PCM range
    step(); cpu_cs = 1'b0; pcm_cs = 1'b1; pcm_addr = 16'hFFFF;
    wait_cond(0, 20, "t2_mem_cs");
    chk("t2_mem_addr", {15'd0, mem_addr}, 32'h11FFF);
    wait_cond(2, 20, "t2_pcm_ok");
    chk("t2_pcm_data", {24'd0, pcm_data}, {24'd0, fdata(17'h11FFF)});
    step(); pcm_cs = 1'b0;

    // Simultaneous misses from reset: PCM first, then alternation
    do_reset();
    cpu_addr = 13'h0010; pcm_addr = 16'h0020; cpu_cs = 1'b1; pcm_cs = 1'b1;
    ng = 0; pcs = mem_cs;
    for (int c = 0; c < 200 && ng < 4; c++) begin
      @(negedge clk);
      if (mem_cs && !pcs) begin grants[ng] = mem_addr; ng++; end
      pcs = mem_cs;
      bump_c = cpu_ok; bump_p = pcm_ok;
      step();
      if (bump_c) cpu_addr = cpu_addr + 13'd1;
      if (bump_p) pcm_addr = pcm_addr + 16'd1;
    end
    chk("t3_grant_count", ng, 32'd4);
    chk("t3_grant0_pcm", {15'd0, grants[0]}, 32'h02020);
    chk("t3_grant1_cpu", {15'd0, grants[1]}, 32'h00010);
    chk("t3_grant2_pcm", {15'd0, grants[2]}, 32'h02021);
    chk("t3_grant3_cpu", {15'd0, grants[3]}, 32'h00011);
    step(); cpu_cs = 1'b0; pcm_cs = 1'b0;
    wait_cond(3, 20, "t3_drain");
    repeat (2) step();

    // Address change while the CPU fill is pending
    cpu_addr = 13'h0001; cpu_cs = 1'b1;
    wait_cond(0, 20, "t4_mem_cs");
    chk("t4_first_addr", {15'd0, mem_addr}, 32'h00001);
    step(); cpu_addr = 13'h0002;
    stable = 1;
    for (int c = 0; c < 50; c++) begin
      @(negedge clk);
      if (!mem_cs) break;
      if (mem_addr != 17'h00001) stable = 0;
    end
    chk("t4_addr_held", {31'd0, stable}, 32'd1);
    chk("t4_ok_low_after_fill", {31'd0, cpu_ok}, 32'd0);
    wait_cond(0, 20, "t4_second_req");
    chk("t4_second_addr", {15'd0, mem_addr}, 32'h00002);
    wait_cond(1, 20, "t4_cpu_ok");
    chk("t4_cpu_data", {24'd0, cpu_data}, {24'd0, fdata(17'h00002)});

    // Reset mid-request; then cs dropped while a fill is pending
    step(); pcm_addr = 16'h0055; pcm_cs = 1'b1;
    wait_cond(0, 20, "t5_mem_cs");
    chk("t5_req_addr", {15'd0, mem_addr}, {15'd0, pslot(16'h0055)});
    step(); rst_n = 1'b0;
    step(); rst_n = 1'b1;
    @(negedge clk);
    chk("t5_mem_cs_dropped", {31'd0, mem_cs}, 32'd0);
    chk("t5_oks_low", {30'd0, cpu_ok, pcm_ok}, 32'd0);
    step(); cpu_cs = 1'b0; pcm_cs = 1'b0;
    wait_cond(3, 20, "t6_fill_done");
    step(); pcm_cs = 1'b1;
    @(negedge clk);
    chk("t6_dropped_cs_filled", {31'd0, pcm_ok}, 32'd1);
    chk("t6_pcm_data", {24'd0, pcm_data}, {24'd0, fdata(pslot(16'h0055))});
    chk("t6_no_slot", {31'd0, mem_cs}, 32'd0);
    step(); pcm_cs = 1'b0;
    repeat (3) step();

    // Randomized two-requester traffic against the model
    do_reset();
    m_cpu_v = 0; m_pcm_v = 0; m_last = 0; cpu_pend = 0; pcm_pend = 0;
    rand_lat = 1; mon_en = 1;
    fork
      drive_cpu(40);
      drive_pcm(40);
    join
    repeat (8) step();
    mon_en = 0;
    chk("rnd_cpu_exp_empty", cpu_exp.size(), 32'd0);
    chk("rnd_pcm_exp_empty", pcm_exp.size(), 32'd0);
    chk("rnd_no_pending", {30'd0, cpu_pend, pcm_pend}, 32'd0);

`ifdef JTSBASKT_ARB_STATS_EN
    // Long stall to push the CPU wait counter into saturation
    do_reset();
    rand_lat = 0; lat = 65600;
    cpu_addr = 13'h0333; cpu_cs = 1'b1;
    repeat (65560) @(posedge clk);
    @(negedge clk);
    chk("stat_cpu_sat", {16'd0, stat_cpu_wait}, 32'h0000FFFF);
    repeat (10) @(posedge clk);
    @(negedge clk);
    chk("stat_cpu_sat_hold", {16'd0, stat_cpu_wait}, 32'h0000FFFF);
    cpu_cs = 1'b0;
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
